// File: rtl/redun_to_bin.sv
// redun_to_bin: converts a redundant-form Montgomery result (NUM_WRDS words of
// WRD_BITS+1 bits) to canonical binary one word per cycle, while in the same
// pass computing X-M so a single conditional subtraction can be selected at the end.
module redun_to_bin #(
    parameter int NUM_WRDS = 4,
    parameter int WRD_BITS = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [WRD_BITS:0]            i_dat [NUM_WRDS],
    input  logic [NUM_WRDS*WRD_BITS-1:0] i_mod,
    input  logic                         i_val,
    output logic                         o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
    output logic                         o_val,
    input  logic                         i_rdy,
    output logic                         o_overflow
);

    localparam int N  = NUM_WRDS * WRD_BITS;
    localparam int KW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

    typedef enum logic [1:0] {IDLE, PROP, SEL, OUT} state_t;

    state_t              state, state_nxt;
    logic [WRD_BITS:0]   dat_sr [NUM_WRDS];  // word 0 always at index 0
    logic [N-1:0]        mod_sr;             // modulus word k always in the low word
    logic [N-1:0]        bin_sr;             // binary words shifted in from the top
    logic [N-1:0]        dif_sr;             // bin - M words shifted in from the top
    logic [1:0]          c;                  // carry chain, 0..2
    logic                b;                  // borrow chain
    logic [KW-1:0]       k;
    logic                accept, hs, last;
    logic [WRD_BITS+1:0] s;
    logic [WRD_BITS:0]   d;
    logic [WRD_BITS-1:0] bin_w, dif_w;

    assign accept = (state == IDLE) && i_val && o_rdy;
    assign hs     = (state == OUT) && o_val && i_rdy;
    assign last   = (k == KW'(NUM_WRDS - 1));

    // One word of both chains: the subtract consumes the freshly formed binary word.
    assign s     = {1'b0, dat_sr[0]} + {{WRD_BITS{1'b0}}, c};
    assign bin_w = s[WRD_BITS-1:0];
    assign d     = {1'b0, bin_w} - {1'b0, mod_sr[WRD_BITS-1:0]} - {{WRD_BITS{1'b0}}, b};
    assign dif_w = d[WRD_BITS-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PROP;
            PROP:    if (last)   state_nxt = SEL;
            SEL:                 state_nxt = OUT;
            OUT:     if (hs)     state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Datapath, chains and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rdy      <= 1'b0;
            o_val      <= 1'b0;
            o_dat      <= '0;
            o_overflow <= 1'b0;
            k          <= '0;
            c          <= '0;
            b          <= 1'b0;
            mod_sr     <= '0;
            bin_sr     <= '0;
            dif_sr     <= '0;
            for (int i = 0; i < NUM_WRDS; i++) dat_sr[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_rdy <= 1'b1;
                    if (accept) begin
                        o_rdy  <= 1'b0;
                        dat_sr <= i_dat;
                        mod_sr <= i_mod;
                        c      <= '0;
                        b      <= 1'b0;
                        k      <= '0;
                    end
                end
                PROP: begin
                    for (int i = 0; i < NUM_WRDS - 1; i++) dat_sr[i] <= dat_sr[i+1];
                    dat_sr[NUM_WRDS-1] <= '0;
                    mod_sr <= mod_sr >> WRD_BITS;
                    bin_sr <= {bin_w, bin_sr[N-1:WRD_BITS]};
                    dif_sr <= {dif_w, dif_sr[N-1:WRD_BITS]};
                    c      <= s[WRD_BITS+1:WRD_BITS];
                    b      <= d[WRD_BITS];
                    k      <= k + 1'b1;
                end
                SEL: begin
                    o_val <= 1'b1;
                    // ct - b < 0 means X < M: keep the plain binary value.
                    if (c < {1'b0, b}) begin
                        o_dat      <= bin_sr;
                        o_overflow <= (c != 2'd0);
                    end else begin
                        o_dat      <= dif_sr;
                        o_overflow <= (c != {1'b0, b});
                    end
                end
                OUT: begin
                    if (hs) begin
                        o_val <= 1'b0;
                        o_rdy <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_to_bin.sv
// Directed bench for redun_to_bin with hand-computed expectations.
module tb_redun_to_bin;

    localparam int NW = 4;
    localparam int WB = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic [WB:0]   i_dat [NW];
    logic [63:0]   i_mod;
    logic          i_val;
    logic          o_rdy;
    logic [63:0]   o_dat;
    logic          o_val;
    logic          i_rdy;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;
    int lat;
    int vcnt;

    redun_to_bin #(.NUM_WRDS(NW), .WRD_BITS(WB)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_dat      (i_dat),
        .i_mod      (i_mod),
        .i_val      (i_val),
        .o_rdy      (o_rdy),
        .o_dat      (o_dat),
        .o_val      (o_val),
        .i_rdy      (i_rdy),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [WB:0] w0, input logic [WB:0] w1,
                          input logic [WB:0] w2, input logic [WB:0] w3,
                          input logic [63:0] m);
        i_dat[0] = w0;
        i_dat[1] = w1;
        i_dat[2] = w2;
        i_dat[3] = w3;
        i_mod    = m;
    endtask

    // Waits (bounded) for o_rdy, then presents one operand for one accept edge.
    task automatic send(input logic [WB:0] w0, input logic [WB:0] w1,
                        input logic [WB:0] w2, input logic [WB:0] w3,
                        input logic [63:0] m);
        int n = 0;
        while (!o_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("rdy_timeout", {63'd0, o_rdy}, 64'd1);
        set_in(w0, w1, w2, w3, m);
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
    endtask

    // Counts cycles from the accept edge until o_val, bounded.
    task automatic wait_val(output int cyc);
        cyc = 0;
        while (!o_val && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("val_timeout", {63'd0, o_val}, 64'd1);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_val   = 1'b0;
        i_rdy   = 1'b1;
        set_in('0, '0, '0, '0, 64'd0);

        // Reset state
        tick(); tick(); tick();
        chk("rst_rdy", {63'd0, o_rdy}, 64'd0);
        chk("rst_val", {63'd0, o_val}, 64'd0);
        chk("rst_dat", o_dat, 64'd0);
        chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", {63'd0, o_rdy}, 64'd1);

        // 1: X=5, M=7 -> 5, latency 5
        send(17'd5, 17'd0, 17'd0, 17'd0, 64'd7);
        chk("t1_rdy_low", {63'd0, o_rdy}, 64'd0);
        wait_val(lat);
        chk("t1_lat", 64'(lat), 64'd5);
        chk("t1_dat", o_dat, 64'd5);
        chk("t1_ovf", {63'd0, o_overflow}, 64'd0);
        tick();
        chk("t1_val_drop", {63'd0, o_val}, 64'd0);
        chk("t1_rdy_back", {63'd0, o_rdy}, 64'd1);

        // 2: X=9, M=7 -> 2; X=7, M=7 -> 0; X=0 -> 0
        send(17'd9, 17'd0, 17'd0, 17'd0, 64'd7);
        wait_val(lat);
        chk("t2a_dat", o_dat, 64'd2);
        chk("t2a_ovf", {63'd0, o_overflow}, 64'd0);
        tick();
        send(17'd7, 17'd0, 17'd0, 17'd0, 64'd7);
        wait_val(lat);
        chk("t2b_dat", o_dat, 64'd0);
        chk("t2b_ovf", {63'd0, o_overflow}, 64'd0);
        tick();
        send(17'd0, 17'd0, 17'd0, 17'd0, 64'd7);
        wait_val(lat);
        chk("t2c_dat", o_dat, 64'd0);
        chk("t2c_ovf", {63'd0, o_overflow}, 64'd0);
        tick();

        // 3: carry ripple, X=2^64, M=2^64-1 -> 1
        send(17'h10000, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_val(lat);
        chk("t3_dat", o_dat, 64'd1);
        chk("t3_ovf", {63'd0, o_overflow}, 64'd0);
        tick();

        // 4: all words max -> overflow
        send(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_val(lat);
        chk("t4_dat", o_dat, 64'h0001_0001_0001_0000);
        chk("t4_ovf", {63'd0, o_overflow}, 64'd1);
        tick();

        // 5: backpressure with a stray i_val while busy
        i_rdy = 1'b0;
        send(17'd9, 17'd0, 17'd0, 17'd0, 64'd7);
        wait_val(lat);
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_val", {63'd0, o_val}, 64'd1);
            chk("t5_hold_dat", o_dat, 64'd2);
            chk("t5_hold_rdy", {63'd0, o_rdy}, 64'd0);
            if (i == 3) begin
                set_in(17'd3, 17'd1, 17'd0, 17'd0, 64'd7);
                i_val = 1'b1;
            end else begin
                i_val = 1'b0;
            end
            tick();
        end
        i_val = 1'b0;
        i_rdy = 1'b1;
        tick();
        chk("t5_val_drop", {63'd0, o_val}, 64'd0);
        chk("t5_rdy_back", {63'd0, o_rdy}, 64'd1);
        chk("t5_dat_kept", o_dat, 64'd2);
        send(17'd12, 17'd0, 17'd0, 17'd0, 64'd7);
        chk("t5_b2b_acc", {63'd0, o_rdy}, 64'd0);
        wait_val(lat);
        chk("t5_b2b_lat", 64'(lat), 64'd5);
        chk("t5_b2b_dat", o_dat, 64'd5);
        tick();

        // 6: reset in PROP at k=2 discards the operation
        send(17'd9, 17'd0, 17'd0, 17'd0, 64'd7);
        tick(); tick();
        i_rst_n = 1'b0;
        tick();
        chk("t6_rst_val", {63'd0, o_val}, 64'd0);
        chk("t6_rst_dat", o_dat, 64'd0);
        chk("t6_rst_rdy", {63'd0, o_rdy}, 64'd0);
        i_rst_n = 1'b1;
        tick();
        chk("t6_rdy_after", {63'd0, o_rdy}, 64'd1);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_val) vcnt++;
            tick();
        end
        chk("t6_no_val", 64'(vcnt), 64'd0);
        send(17'd5, 17'd0, 17'd0, 17'd0, 64'd7);
        wait_val(lat);
        chk("t6_lat", 64'(lat), 64'd5);
        chk("t6_dat", o_dat, 64'd5);
        chk("t6_ovf", {63'd0, o_overflow}, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
